// File: rtl/exec_alu_md.sv
// exec_alu_md: execute-stage ALU with an iterative unsigned multiply/divide unit.
//
// Single-cycle ops (add/sub/logic/compare/shift) resolve combinationally.
// mul/mulhu/divu/remu run a three-state FSM (IDLE, BUSY, DONE). While the FSM
// works, the E stage is stalled. DoneE pulses for one cycle with the M result
// on ALUResultE, and the pipeline advances on that edge.
//
// Optional build macro: ALU_FAST_MUL_EN
//   defined   - mul/mulhu use a single-cycle 2*WIDTH multiplier in IDLE and
//               go straight to DONE. Divide stays iterative.
//   undefined - mul/mulhu use iterative shift-add. No multiplier is inferred.
//
// Parameters:
//   WIDTH  datapath width (even, 8..64)
//
// Ports:
//   clk          core clock, rising edge
//   reset        asynchronous active-high reset
//   SrcAE        operand A (rs1 path)
//   SrcBE        operand B (rs2/imm path)
//   AluControlE  op select
//   ValidE       E stage holds a valid instruction
//   ALUResultE   result
//   ZeroE        ALUResultE == 0
//   OvfE         signed overflow for add/sub, otherwise 0
//   StallE       hold F/D/E while an M op is in progress
//   BusyE        FSM in BUSY
//   DoneE        one-cycle pulse; M result valid on ALUResultE
module exec_alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [3:0]       AluControlE,
  input  logic             ValidE,
  output logic [WIDTH-1:0] ALUResultE,
  output logic             ZeroE,
  output logic             OvfE,
  output logic             StallE,
  output logic             BusyE,
  output logic             DoneE
);

  localparam int CNTW = $clog2(WIDTH) + 1;
  localparam int SHW  = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLT   = 4'h5,
    OP_SLTU  = 4'h6,
    OP_SLL   = 4'h7,
    OP_SRL   = 4'h8,
    OP_SRA   = 4'h9,
    OP_MUL   = 4'hA,
    OP_MULHU = 4'hB,
    OP_DIVU  = 4'hC,
    OP_REMU  = 4'hD
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e state, state_nx;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  logic             is_md, is_div, start;
  logic             sub_op, cout, ovf_raw;
  logic [WIDTH-1:0] b_opnd, sum, alu_res, md_res;
  logic [SHW-1:0]   shamt;

  assign is_md  = (AluControlE >= OP_MUL) && (AluControlE <= OP_REMU);
  // Within the M group, bit 2 separates divide (11xx) from multiply (101x).
  assign is_div = AluControlE[2];
  assign start  = ValidE & is_md;

  // Subtract and both compares share one adder: A + ~B + 1.
  assign sub_op = (AluControlE == OP_SUB) || (AluControlE == OP_SLT) ||
                  (AluControlE == OP_SLTU);
  assign b_opnd = sub_op ? ~SrcBE : SrcBE;
  assign {cout, sum} = {1'b0, SrcAE} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, sub_op};
  assign ovf_raw = ~(sub_op ^ SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]) &
                   (SrcAE[WIDTH-1] ^ sum[WIDTH-1]);
  assign shamt   = SrcBE[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (AluControlE)
      OP_ADD, OP_SUB: alu_res = sum;
      OP_AND:         alu_res = SrcAE & SrcBE;
      OP_OR:          alu_res = SrcAE | SrcBE;
      OP_XOR:         alu_res = SrcAE ^ SrcBE;
      OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
      OP_SLTU:        alu_res = {{(WIDTH-1){1'b0}}, ~cout};
      OP_SLL:         alu_res = SrcAE << shamt;
      OP_SRL:         alu_res = SrcAE >> shamt;
      OP_SRA:         alu_res = $signed(SrcAE) >>> shamt;
      default:        alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide datapath registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   opb, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic [CNTW-1:0]    cnt;
  logic               md_div, md_sel;
  logic [WIDTH:0]     rsh, trial;

  // Restoring divide step: shift the next dividend bit into the remainder and
  // keep the difference only when it does not borrow.
  assign rsh   = {rem, quo[WIDTH-1]};
  assign trial = rsh - {1'b0, opb};

`ifndef ALU_FAST_MUL_EN
  logic [WIDTH-1:0] opa;
  logic [WIDTH:0]   psum;

  // Shift-add step: the low half of prod holds the unconsumed multiplier bits,
  // the high half accumulates; the carry of each add shifts in from the top.
  assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opb    <= '0;
      quo    <= '0;
      rem    <= '0;
      prod   <= '0;
      cnt    <= '0;
      md_div <= 1'b0;
      md_sel <= 1'b0;
`ifndef ALU_FAST_MUL_EN
      opa    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opb    <= SrcBE;
            md_div <= is_div;
            md_sel <= AluControlE[0];
            cnt    <= CNTW'(WIDTH);
            if (is_div) begin
              if (SrcBE == '0) begin
                quo <= '1;
                rem <= SrcAE;
              end else begin
                quo <= SrcAE;
                rem <= '0;
              end
            end else begin
`ifdef ALU_FAST_MUL_EN
              prod <= (2*WIDTH)'(SrcAE) * (2*WIDTH)'(SrcBE);
`else
              opa  <= SrcAE;
              prod <= {{WIDTH{1'b0}}, SrcBE};
`endif
            end
          end
        end
        S_BUSY: begin
          if (ValidE) begin
            cnt <= cnt - CNTW'(1);
            if (md_div) begin
              quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
              rem <= trial[WIDTH] ? rsh[WIDTH-1:0] : trial[WIDTH-1:0];
            end
`ifndef ALU_FAST_MUL_EN
            else begin
              prod <= {psum, prod[WIDTH-1:1]};
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_div && (SrcBE == '0)) state_nx = S_DONE;
`ifdef ALU_FAST_MUL_EN
          else if (!is_div)            state_nx = S_DONE;
`endif
          else                         state_nx = S_BUSY;
        end
      end
      // A dropped ValidE is a flush: abandon the op without a DONE pulse.
      S_BUSY: begin
        if (!ValidE)                 state_nx = S_IDLE;
        else if (cnt == CNTW'(1))    state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    md_res = '0;
    case ({md_div, md_sel})
      2'b00:   md_res = prod[WIDTH-1:0];
      2'b01:   md_res = prod[2*WIDTH-1:WIDTH];
      2'b10:   md_res = quo;
      default: md_res = rem;
    endcase
  end

  assign BusyE      = (state == S_BUSY);
  assign DoneE      = (state == S_DONE);
  assign StallE     = ValidE & is_md & ~DoneE;
  assign ALUResultE = DoneE ? md_res : (is_md ? '0 : alu_res);
  assign ZeroE      = (ALUResultE == '0);
  assign OvfE       = ((AluControlE == OP_ADD) || (AluControlE == OP_SUB)) & ovf_raw;

endmodule

// File: doc/exec_alu_md.md
Name: exec_alu_md

Overview:
- Parametrised execute-stage ALU for the pipelined RISC-V core; the next generation of the single-cycle ALU.
- Width is generalised, the op set is widened (xor, sltu, shifts), and an iterative unsigned multiply/divide unit is added.
- Single-cycle ops resolve combinationally in E.
- Multiply/divide ops run a multi-cycle FSM and stall the pipeline through `StallE` until the result is ready.

Parameters:
- WIDTH, 32, datapath width; legal values are 8 to 64, even only.
- CNTW, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- SrcAE  in  WIDTH  operand A (rs1 path)
- SrcBE  in  WIDTH  operand B (rs2/imm path)
- AluControlE  in  4  op select
- ValidE  in  1  E stage holds a valid instruction
- ALUResultE  out  WIDTH  result
- ZeroE  out  1  ALUResultE == 0
- OvfE  out  1  signed overflow; add/sub only, else 0
- StallE  out  1  hold F/D/E; M op in progress
- BusyE  out  1  FSM in BUSY
- DoneE  out  1  one-cycle pulse; M result valid on ALUResultE

Behaviour:
- Op encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 slt (signed), 0110 sltu.
  - 0111 sll, 1000 srl, 1001 sra; shift amount = SrcBE[$clog2(WIDTH)-1:0].
  - 1010 mul (low WIDTH bits), 1011 mulhu (high WIDTH bits, unsigned).
  - 1100 divu, 1101 remu.
  - 1110/1111 give result 0, no stall.
- isMD = AluControlE in 1010..1101.
- Sub and compares use A + ~B + 1. slt = sum MSB XOR overflow; sltu = borrow (no carry out).
- OvfE = ~(sub ^ A[MSB] ^ B[MSB]) & (A[MSB] ^ sum[MSB]), gated to add/sub.
- FSM states are IDLE, BUSY, DONE. Reset forces IDLE, counter 0, product/quotient/remainder registers 0, BusyE 0, DoneE 0.
- IDLE:
  - If ValidE & isMD, latch SrcAE, SrcBE and op.
  - Mul or div with SrcBE != 0: counter := WIDTH, go to BUSY.
  - divu/remu with SrcBE == 0: go directly to DONE with quotient = all ones, remainder = SrcAE.
- BUSY, one iteration per cycle:
  - mul: shift-add over a 2*WIDTH product.
  - div: restoring shift-subtract.
  - Counter decrements; on counter == 1 go to DONE.
- DONE: DoneE = 1; ALUResultE = the selected MD result register. Next state is IDLE unconditionally.
- Latency: an M op presented at cycle T gives DoneE at T+WIDTH+1 (T+1 for divide-by-zero).
- Back-to-back M ops: the second starts in the IDLE cycle after DONE.
- StallE = ValidE & isMD & ~DoneE, combinational. The pipeline advances on the DONE edge.
- ALUResultE:
  - DONE: MD result.
  - Otherwise, isMD: 0.
  - Otherwise: combinational ALU result.
  - ZeroE always tracks ALUResultE.
- Flush (ValidE low in BUSY): abort to IDLE next cycle with no DoneE pulse; MD registers need not clear.
- Operands change while BUSY: ignored; the latched copies are used.
- Reset asserted mid-operation: immediate IDLE, outputs to reset values, no DoneE.

Optional Feature:
- Macro: ALU_FAST_MUL_EN.
- Defined:
  - mul/mulhu compute a full 2*WIDTH product with a single-cycle multiplier in IDLE, register it, and go directly to DONE; latency is T+1.
  - Divide is unchanged.
- Undefined: iterative shift-add multiply as above; no multiplier inferred.

Test Plan (WIDTH=32):
- add A=0x7FFFFFFF, B=1 -> ALUResultE 0x80000000, OvfE 1, StallE 0; sub A=5, B=5 -> result 0, ZeroE 1.
- slt A=0xFFFFFFFF, B=1 -> 1; sltu same operands -> 0; sra A=0x80000000, B=4 -> 0xF8000000; sll with B=0x21 -> shift by 1.
- mul A=0xFFFFFFFF, B=0xFFFFFFFF held with ValidE=1 -> StallE high for 33 cycles, DoneE at T+33, result 0x00000001; mulhu same operands -> 0xFFFFFFFE.
- divu 100/7 -> 14; remu -> 2 (DoneE at T+33); divu 100/0 -> 0xFFFFFFFF and remu 100/0 -> 100, DoneE at T+1.
- Start divu, drop ValidE at T+10 -> IDLE at T+11, no DoneE; assert reset during BUSY -> BusyE/DoneE 0 immediately.
- ALU_FAST_MUL_EN defined: mul 1234*5678 -> 7006652 with DoneE at T+1; back-to-back mul, mul -> second DoneE at T+3.
